// File: rtl/tile_bitmap_pkg.sv
// Shared constants, types and ROM artwork for the tile bitmap engine.
// Holds the transparent colour code, the hit-edge bit positions, the tile
// index names, an index-width helper, and the function that defines the
// contents of every tile bitmap.
package tile_bitmap_pkg;

  localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

  // Bit positions inside hitEdgeCode.
  localparam int unsigned HIT_LEFT   = 3;
  localparam int unsigned HIT_TOP    = 2;
  localparam int unsigned HIT_RIGHT  = 1;
  localparam int unsigned HIT_BOTTOM = 0;

  // Tile type selectors.
  localparam int unsigned TILE_BRICK  = 0;
  localparam int unsigned TILE_LADDER = 1;
  localparam int unsigned TILE_DOOR   = 2;
  localparam int unsigned TILE_WATER  = 3;

  // Edge flags in hitEdgeCode order {Left, Top, Right, Bottom}.
  typedef struct packed {
    logic left;
    logic top;
    logic right;
    logic bottom;
  } hit_edge_t;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Tile artwork: a colour ramp that shifts per tile and per animation frame,
  // punched with a transparent diagonal lattice.
  function automatic logic [7:0] rom_pixel(input int tile, input int frame,
                                           input int y, input int x);
    if (((x ^ y) & 7) == 7) return TRANSPARENT_ENCODING;
    return 8'(17 + tile * 37 + frame * 91 + y * 5 + x * 3);
  endfunction

endpackage

// File: rtl/tile_bitmap_if.sv
// Pixel request / pixel response bundle between the tile scanner and the
// bitmap engine.
//   pixelX, pixelY   : offset from tile top-left (only low bits are used)
//   objectExists     : pixel lies inside a tile bracket
//   tileIndex        : tile type selector
//   drawingRequest   : pixel is opaque
//   RGBout           : RGB332 pixel colour
//   hitEdgeCode      : {Left, Top, Right, Bottom} edge flags
interface tile_bitmap_if #(
  parameter int unsigned TILE_IDX_W = 2
);
  logic [10:0]           pixelX;
  logic [10:0]           pixelY;
  logic                  objectExists;
  logic [TILE_IDX_W-1:0] tileIndex;
  logic                  drawingRequest;
  logic [7:0]            RGBout;
  logic [3:0]            hitEdgeCode;

  modport master (
    output pixelX, pixelY, objectExists, tileIndex,
    input  drawingRequest, RGBout, hitEdgeCode
  );

  modport slave (
    input  pixelX, pixelY, objectExists, tileIndex,
    output drawingRequest, RGBout, hitEdgeCode
  );
endinterface

// File: rtl/tile_bitmap_engine_anim.sv
// tile_anim_counter: animation prescaler and frame counter.
//   clk, resetN   : clock, asynchronous active-low reset
//   startOfFrame  : one pulse per video frame
//   animEnable    : when low, prescaler and frame both hold
//   frame         : current animation frame (registered)
module tile_anim_counter
  import tile_bitmap_pkg::*;
#(
  parameter int unsigned NUM_FRAMES  = 2,
  parameter int unsigned ANIM_PERIOD = 8,
  parameter int unsigned FRAME_W     = 1
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               animEnable,
  output logic [FRAME_W-1:0] frame
);

  localparam logic [7:0]         PRESC_LAST = 8'(ANIM_PERIOD - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(NUM_FRAMES - 1);

  logic [7:0]         presc_q, presc_d;
  logic [FRAME_W-1:0] frame_q, frame_d;

  // Count enabled frame pulses; the last count of a period steps the frame.
  always_comb begin
    presc_d = presc_q;
    frame_d = frame_q;
    if (startOfFrame && animEnable) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        frame_d = (frame_q == FRAME_LAST) ? '0 : frame_q + FRAME_W'(1);
      end else begin
        presc_d = presc_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      presc_q <= '0;
      frame_q <= '0;
    end else begin
      presc_q <= presc_d;
      frame_q <= frame_d;
    end
  end

  assign frame = frame_q;

endmodule

// File: rtl/tile_bitmap_engine.sv
// tile_bitmap_engine: two-stage tile bitmap lookup with animation.
//   clk, resetN   : pixel clock, asynchronous active-low reset
//   startOfFrame  : one pulse per video frame (animation timebase)
//   animEnable    : allow animation to advance
//   bus (slave)   : pixel request in, RGBout / drawingRequest / hitEdgeCode out
// Stage 1 captures tile, frame, masked coordinates and objectExists; stage 2
// registers the ROM colour, so RGBout trails the request by two clocks.
// Optional feature macro: TILE_HIT_EDGE_EN enables the hitEdgeCode logic;
// when undefined hitEdgeCode is tied to zero.
module tile_bitmap_engine
  import tile_bitmap_pkg::*;
#(
  parameter int unsigned TILE_BITS   = 5,
  parameter int unsigned NUM_TILES   = 4,
  parameter int unsigned NUM_FRAMES  = 2,
  parameter int unsigned ANIM_PERIOD = 8
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         startOfFrame,
  input  logic         animEnable,
  tile_bitmap_if.slave bus
);

  localparam int unsigned TILE_PX    = 1 << TILE_BITS;
  localparam int unsigned TILE_IDX_W = idx_w(NUM_TILES);
  localparam int unsigned FRAME_W    = idx_w(NUM_FRAMES);

  // Constant bitmap table [tile][frame][y][x].
  logic [7:0] rom [NUM_TILES][NUM_FRAMES][TILE_PX][TILE_PX];

  for (genvar t = 0; t < NUM_TILES; t++) begin : g_tile
    for (genvar f = 0; f < NUM_FRAMES; f++) begin : g_frame
      for (genvar y = 0; y < TILE_PX; y++) begin : g_row
        for (genvar x = 0; x < TILE_PX; x++) begin : g_col
          assign rom[t][f][y][x] = rom_pixel(t, f, y, x);
        end
      end
    end
  end

  logic [FRAME_W-1:0] anim_frame;

  tile_anim_counter #(
    .NUM_FRAMES  (NUM_FRAMES),
    .ANIM_PERIOD (ANIM_PERIOD),
    .FRAME_W     (FRAME_W)
  ) u_anim (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .animEnable   (animEnable),
    .frame        (anim_frame)
  );

  // Stage 1 registers.
  logic [TILE_IDX_W-1:0] tile_q,   tile_d;
  logic [FRAME_W-1:0]    frame_q,  frame_d;
  logic [TILE_BITS-1:0]  x_q,      x_d;
  logic [TILE_BITS-1:0]  y_q,      y_d;
  logic                  exists_q, exists_d;

  // Stage 2 registers.
  logic [7:0]            rgb_q,    rgb_d;

  logic                  tile_ok;
  logic [TILE_IDX_W-1:0] tile_rd;

  // Tile repeats: coordinate bits above the tile edge are dropped.
  logic unused_coord_hi;
  assign unused_coord_hi = ^{bus.pixelX[10:TILE_BITS], bus.pixelY[10:TILE_BITS]};

  // Stage 1 capture; frame is sampled here only.
  always_comb begin
    tile_d   = bus.tileIndex;
    frame_d  = anim_frame;
    x_d      = bus.pixelX[TILE_BITS-1:0];
    y_d      = bus.pixelY[TILE_BITS-1:0];
    exists_d = bus.objectExists;
  end

  // Range check against the populated tiles, then clamp the read index.
  always_comb begin
    tile_ok = 1'b0;
    for (int unsigned i = 0; i < NUM_TILES; i++) begin
      if (tile_q == TILE_IDX_W'(i)) tile_ok = 1'b1;
    end
    tile_rd = tile_ok ? tile_q : '0;
  end

  // Stage 2 colour lookup.
  always_comb begin
    rgb_d = TRANSPARENT_ENCODING;
    if (exists_q && tile_ok) rgb_d = rom[tile_rd][frame_q][y_q][x_q];
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      tile_q   <= '0;
      frame_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      exists_q <= 1'b0;
      rgb_q    <= 8'h00;
    end else begin
      tile_q   <= tile_d;
      frame_q  <= frame_d;
      x_q      <= x_d;
      y_q      <= y_d;
      exists_q <= exists_d;
      rgb_q    <= rgb_d;
    end
  end

  assign bus.RGBout         = rgb_q;
  assign bus.drawingRequest = (rgb_q != TRANSPARENT_ENCODING);

`ifdef TILE_HIT_EDGE_EN
  hit_edge_t hit_q, hit_d;

  // Outermost quarter on each side: top two coordinate bits 00 or 11.
  always_comb begin
    hit_d = '0;
    if (exists_q) begin
      hit_d.left   = (x_q[TILE_BITS-1 -: 2] == 2'b00);
      hit_d.top    = (y_q[TILE_BITS-1 -: 2] == 2'b00);
      hit_d.right  = (x_q[TILE_BITS-1 -: 2] == 2'b11);
      hit_d.bottom = (y_q[TILE_BITS-1 -: 2] == 2'b11);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) hit_q <= '0;
    else         hit_q <= hit_d;
  end

  assign bus.hitEdgeCode = hit_q;
`else
  assign bus.hitEdgeCode = 4'b0000;
`endif

endmodule

// File: doc/tile_bitmap_engine.md
TILE_BITMAP_ENGINE -- requirements
Module: tile_bitmap_engine

Interface
REQ-001 Parameter TILE_BITS, default 5, log2 of tile edge in pixels (tile is 2^TILE_BITS square).
REQ-002 Parameter NUM_TILES, default 4, number of distinct tile bitmaps (brick, ladder, door, water...).
REQ-003 Parameter NUM_FRAMES, default 2, animation frames per tile.
REQ-004 Parameter ANIM_PERIOD, default 8, video frames per animation step (1..255).
REQ-005 clk  input  1  pixel clock.
REQ-006 resetN  input  1  reset, asynchronous, active-low.
REQ-007 pixelX  input  11  X offset from tile top-left.
REQ-008 pixelY  input  11  Y offset from tile top-left.
REQ-009 objectExists  input  1  pixel is inside a tile bracket.
REQ-010 tileIndex  input  $clog2(NUM_TILES)  tile type selector for current pixel.
REQ-011 startOfFrame  input  1  single-cycle pulse at start of each video frame.
REQ-012 animEnable  input  1  allow animation to advance.
REQ-013 drawingRequest  output  1  pixel is opaque and shall be displayed.
REQ-014 RGBout  output  8  RGB332 colour of pixel.
REQ-015 hitEdgeCode  output  4  {Left, Top, Right, Bottom} edge flags for collision.

Function
REQ-016 Only pixelX/pixelY bits [TILE_BITS-1:0] SHALL be used; higher bits are ignored (tiles repeat).
REQ-017 Stage 1 SHALL register tileIndex, current animation frame, masked X/Y and objectExists.
REQ-018 Stage 2 SHALL register RGBout from ROM[tile][frame][y][x]; total input-to-RGBout latency exactly 2 clk cycles.
REQ-019 When stage-1 objectExists is 0, RGBout SHALL be TRANSPARENT_ENCODING (8'hFF) on the following cycle.
REQ-020 tileIndex >= NUM_TILES SHALL yield RGBout = 8'hFF.
REQ-021 drawingRequest SHALL be combinational: 1 iff RGBout != 8'hFF.
REQ-022 Animation: a prescaler SHALL count startOfFrame pulses while animEnable=1; on reaching ANIM_PERIOD-1 it clears and frame advances by 1.
REQ-023 Frame SHALL wrap NUM_FRAMES-1 -> 0; with NUM_FRAMES=1 frame stays 0.
REQ-024 animEnable=0 SHALL hold both prescaler and frame; startOfFrame pulses are ignored.
REQ-025 Frame change SHALL be sampled only at stage 1, so a pixel already in stage 2 uses its captured frame.
REQ-026 hitEdgeCode bit set when pixel lies in outermost 1/4 of tile on that edge (top two bits of masked coordinate 00 -> Left/Top, 11 -> Right/Bottom); corners set two bits; 0 when not objectExists; same 2-cycle latency as RGBout.

Reset
REQ-027 On resetN low: RGBout = 8'h00, hitEdgeCode = 0, all pipeline registers, prescaler and frame = 0, immediately and asynchronously.
REQ-028 drawingRequest SHALL be 1 during reset (RGBout 8'h00 != 8'hFF); downstream mixers gate on resetN.
REQ-029 Reset mid-frame SHALL restart animation at frame 0, prescaler 0.

Configuration
REQ-030 Macro TILE_HIT_EDGE_EN defined: hitEdgeCode generated per REQ-026.
REQ-031 Macro TILE_HIT_EDGE_EN undefined: hitEdgeCode tied to 4'b0000, no edge logic synthesised; RGB path unchanged.

Structure
REQ-032 Package tile_bitmap_pkg SHALL hold TRANSPARENT_ENCODING, hit-edge bit positions (HIT_LEFT=3, HIT_TOP=2, HIT_RIGHT=1, HIT_BOTTOM=0) and tile index constants (TILE_BRICK=0, ...).
REQ-033 Sub-module tile_anim_counter SHALL implement prescaler and frame counter (REQ-022..024, 029).
REQ-034 Bitmap ROM contents SHALL be constant arrays indexed [tile][frame][y][x], inferred as ROM.

Verification
REQ-035 tileIndex=0, frame 0, X=0,Y=0, objectExists=1 -> RGBout = ROM[0][0][0][0] exactly 2 cycles later, drawingRequest=1.
REQ-036 objectExists=0 any coords -> RGBout=8'hFF, drawingRequest=0, hitEdgeCode=0 after 2 cycles.
REQ-037 ANIM_PERIOD=8, NUM_FRAMES=2, animEnable=1, 8 startOfFrame pulses -> frame 0->1; 16 pulses -> back to 0; animEnable=0 with 8 pulses -> frame unchanged.
REQ-038 pixelX=31,pixelY=0 (TILE_BITS=5) with TILE_HIT_EDGE_EN -> hitEdgeCode=4'b0110; pixelX=40 -> same pixel as X=8, hitEdgeCode=4'b0100.
REQ-039 tileIndex=NUM_TILES (non-power-of-two NUM_TILES=3, index 3) -> RGBout=8'hFF.
REQ-040 resetN asserted after 5 animation steps mid-line -> RGBout=8'h00, frame=0 immediately; first pixel after release appears 2 cycles later with frame 0.
